// File: rtl/conversor_gray_binario_pkg.sv
// Shared types and defaults for the Gray-to-binary position tracker.
package conversor_gray_binario_pkg;

  localparam int unsigned WIDTH_PADRAO     = 4;
  localparam int unsigned POS_WIDTH_PADRAO = 8;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    RASTREIO = 2'd1,
    ERRO     = 2'd2
  } estado_t;

endpackage

// File: rtl/conversor_gray_binario_decod.sv
// Combinational Gray-to-binary decoder: running XOR from the MSB downwards.
module gray_para_binario #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binario_c
);

  always_comb begin : decod
    logic acc;
    acc       = gray[WIDTH-1];
    binario_c = '0;
    binario_c[WIDTH-1] = acc;
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      acc          = acc ^ gray[i];
      binario_c[i] = acc;
    end
  end

endmodule

// File: rtl/conversor_gray_binario.sv
// Synchronizes an asynchronous Gray input, decodes it and tracks +1/-1 steps
// into a saturating signed position, flagging illegal jumps.
module conversor_gray_binario
  import conversor_gray_binario_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_PADRAO,
  parameter int unsigned POS_WIDTH = POS_WIDTH_PADRAO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray,
  input  logic                 en,
  input  logic                 limpa,
  output logic [WIDTH-1:0]     binario,
  output logic                 valid,
  output logic                 sobe,
  output logic                 desce,
  output logic                 erro,
  output logic [POS_WIDTH-1:0] posicao
);

  localparam logic [WIDTH-1:0]     PASSO_SOBE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]     PASSO_DESCE = '1;
  localparam logic [POS_WIDTH-1:0] POS_MAX     = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] POS_MIN     = {1'b1, {(POS_WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]     sinc1, sinc2;
  logic [WIDTH-1:0]     bin_c, delta_c;
  estado_t              estado, estado_nxt;
  logic [WIDTH-1:0]     binario_nxt;
  logic                 valid_nxt, sobe_nxt, desce_nxt, erro_nxt;
  logic [POS_WIDTH-1:0] posicao_nxt;

  // Two-flop synchronizer, free-running regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1 <= '0;
      sinc2 <= '0;
    end else begin
      sinc1 <= gray;
      sinc2 <= sinc1;
    end
  end

  gray_para_binario #(.WIDTH(WIDTH)) u_decod (
    .gray      (sinc2),
    .binario_c (bin_c)
  );

  // Modulo-2^WIDTH difference makes the wrap-around a legal single step.
  assign delta_c = bin_c - binario;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= INICIO;
      binario <= '0;
      valid   <= 1'b0;
      sobe    <= 1'b0;
      desce   <= 1'b0;
      erro    <= 1'b0;
      posicao <= '0;
    end else begin
      estado  <= estado_nxt;
      binario <= binario_nxt;
      valid   <= valid_nxt;
      sobe    <= sobe_nxt;
      desce   <= desce_nxt;
      erro    <= erro_nxt;
      posicao <= posicao_nxt;
    end
  end

  // limpa wins over en; binario keeps decoding even after an error.
  always_comb begin
    estado_nxt  = estado;
    binario_nxt = binario;
    valid_nxt   = valid;
    sobe_nxt    = 1'b0;
    desce_nxt   = 1'b0;
    erro_nxt    = erro;
    posicao_nxt = posicao;

    if (limpa) begin
      estado_nxt  = INICIO;
      valid_nxt   = 1'b0;
      erro_nxt    = 1'b0;
      posicao_nxt = '0;
    end else if (en) begin
      binario_nxt = bin_c;
      case (estado)
        INICIO: begin
          valid_nxt  = 1'b1;
          estado_nxt = RASTREIO;
        end
        RASTREIO: begin
          if (delta_c == PASSO_SOBE) begin
            sobe_nxt = 1'b1;
            if (posicao != POS_MAX) posicao_nxt = posicao + POS_WIDTH'(1);
          end else if (delta_c == PASSO_DESCE) begin
            desce_nxt = 1'b1;
            if (posicao != POS_MIN) posicao_nxt = posicao - POS_WIDTH'(1);
          end else if (delta_c != '0) begin
            erro_nxt   = 1'b1;
            estado_nxt = ERRO;
          end
        end
        ERRO: begin
          erro_nxt = 1'b1;
        end
        default: begin
          estado_nxt = INICIO;
        end
      endcase
    end
  end

endmodule
